uart_word_assembler: RTL and testbench
======================================

// Module: uart_word_assembler
// PURPOSE
//   Consumes the byte stream from the UART receive stage and packs every four bytes into a
//   little-endian 32-bit word for the Phaethon core. Completed words are buffered in a small FIFO
//   and handed out on a valid/ready interface. A partial word is discarded if the line goes idle
//   too long. FIFO overflow is recorded and counted.
// PARAMETERS
//   FIFO_DEPTH      4     word entries in output FIFO; power of two, >= 2
//   TIMEOUT_CYCLES  8680  clk cycles of no byte (20 bit times at 434 clk/bit) before partial discard
// PORTS
//   clk            in   1       system clock; all logic on posedge clk
//   reset          in   1       synchronous, active-high reset
//   byteValid      in   1       one-cycle strobe: byteData holds a newly received byte
//   byteData       in   8       received byte, sampled only when byteValid=1
//   wordValid      out  1       FIFO non-empty; wordData is valid
//   wordData       out  32      FIFO head word
//   wordReady      in   1       consumer accepts head word when wordValid&&wordReady
//   fifoCount      out  $clog2(FIFO_DEPTH)+1  words currently buffered
//   byteCount      out  2       bytes held in partial word (0..3)
//   timeoutPulse   out  1       one-cycle pulse when a partial word is discarded by timeout
//   overflow       out  1       sticky: a completed word was dropped because FIFO was full
//   dropCount      out  16      completed words dropped; saturates at 16'hFFFF
//   clearStatus    in   1       clears overflow and dropCount
// BEHAVIOUR
//   Reset (sync, active-high, sampled at posedge clk): FIFO empty; partial word discarded; idle
//     counter 0. All outputs 0: wordValid, wordData, fifoCount, byteCount, timeoutPulse, overflow,
//     dropCount. Reset mid-word or with a non-empty FIFO discards everything. No output holds state.
//   Assembly FSM: COLLECT0..COLLECT3. The state index equals byteCount.
//     On byteValid in COLLECTk, byteData is written to bits [8k+7:8k]. State goes to k+1.
//     From COLLECT3 it goes to COLLECT0, and the word completes on that edge.
//     First byte received = bits [7:0]. Fourth byte = bits [31:24].
//   Push: a completed word is written into the FIFO on the same edge as its 4th byte.
//     If the FIFO was empty, wordValid=1 in the next cycle (1-cycle latency from last byteValid).
//   Pop: on wordValid&&wordReady the head entry is removed at the edge.
//     wordData must stay stable while wordValid=1 and wordReady=0.
//     wordData is don't-care when wordValid=0.
//   Full: completing a word while fifoCount==FIFO_DEPTH and there is no pop that cycle
//     -> word dropped; overflow<=1; dropCount+1 (saturating); FSM still returns to COLLECT0.
//   Simultaneous push+pop when full: both happen; the word is not dropped; fifoCount unchanged.
//   Simultaneous push+pop when non-empty and not full: fifoCount unchanged; FIFO order preserved.
//   Wrap-around: read and write pointers wrap modulo FIFO_DEPTH.
//     fifoCount distinguishes full from empty.
//   Timeout: the idle counter is active only when byteCount!=0.
//     It resets to 0 on every byteValid and whenever byteCount==0.
//     It increments each cycle without byteValid.
//     When it reaches TIMEOUT_CYCLES-1: byteCount<=0, partial bits discarded, timeoutPulse=1 for
//     one cycle, counter<=0.
//     If byteValid coincides with the expiry cycle, the byte wins: it is assembled and the counter
//     restarts. No timeout occurs.
//   clearStatus: overflow<=0, dropCount<=0.
//     If a drop occurs in the same cycle, the drop wins over the clear: overflow=1, dropCount=1.
//   clearStatus does not affect the FIFO or the assembly state.
// TESTING
//   1. Bytes 11,22,33,44 strobed -> wordValid rises 1 cycle after 4th strobe; wordData=32'h44332211.
//   2. Depth=4, wordReady=0, 5 words sent -> fifoCount=4; overflow=1; dropCount=1;
//      drain yields the first 4 words in order.
//   3. Bytes AA,BB then idle TIMEOUT_CYCLES -> timeoutPulse once; byteCount=0;
//      next 4 bytes 01,02,03,04 -> 32'h04030201.
//   4. FIFO full with wordReady=1 held while the 4th byte of a new word arrives -> no drop;
//      fifoCount stays 4; new word emerges last.
//   5. Assert reset after 2 bytes with 3 words queued -> next cycle all outputs 0;
//      then 4 bytes produce one correct word.
//   6. Byte strobe exactly on the timeout-expiry cycle -> no timeoutPulse; byteCount increments.

Source files
------------

// File: rtl/uart_word_assembler.sv
// Packs a UART byte stream into little-endian 32-bit words and buffers them in a small FIFO.
// Partial words are dropped after a long idle gap. FIFO overflow is recorded and counted.
module uart_word_assembler #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8680
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          byteValid,
    input  logic [7:0]                    byteData,
    output logic                          wordValid,
    output logic [31:0]                   wordData,
    input  logic                          wordReady,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic [1:0]                    byteCount,
    output logic                          timeoutPulse,
    output logic                          overflow,
    output logic [15:0]                   dropCount,
    input  logic                          clearStatus
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        COLLECT0 = 2'd0,
        COLLECT1 = 2'd1,
        COLLECT2 = 2'd2,
        COLLECT3 = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [23:0]         asm_q, asm_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                pulse_q, pulse_d;
    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [31:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                word_valid_q, word_valid_d;
    logic [31:0]         word_data_q, word_data_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [15:0]         drop_base;
    logic                complete, pop, push, drop, full;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COLLECT0;
            asm_q        <= '0;
            idle_q       <= '0;
            pulse_q      <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            ovf_q        <= 1'b0;
            drop_cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            asm_q        <= asm_d;
            idle_q       <= idle_d;
            pulse_q      <= pulse_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            ovf_q        <= ovf_d;
            drop_cnt_q   <= drop_cnt_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Assembly FSM, idle timeout, FIFO and status next-state
    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        idle_d     = idle_q;
        pulse_d    = 1'b0;
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        complete   = 1'b0;
        drop_base  = drop_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;

        if (byteValid) begin
            idle_d = '0;
            case (state_q)
                COLLECT0: begin asm_d[7:0]   = byteData; state_d = COLLECT1; end
                COLLECT1: begin asm_d[15:8]  = byteData; state_d = COLLECT2; end
                COLLECT2: begin asm_d[23:16] = byteData; state_d = COLLECT3; end
                COLLECT3: begin complete = 1'b1;          state_d = COLLECT0; end
            endcase
        end else if (state_q != COLLECT0) begin
            // A byte arriving on the expiry cycle takes the branch above instead
            if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = COLLECT0;
                asm_d   = '0;
                idle_d  = '0;
                pulse_d = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end else begin
            idle_d = '0;
        end

        full = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop  = word_valid_q && wordReady;
        push = complete && (!full || pop);
        drop = complete && full && !pop;

        if (push) begin
            mem_d[wr_q] = {byteData, asm_q};
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
        word_valid_d = (cnt_d != '0);
        word_data_d  = mem_d[rd_d];

        // A drop in the same cycle as a clear leaves the status showing that drop
        if (clearStatus) begin
            drop_base = '0;
            ovf_d     = 1'b0;
        end
        drop_cnt_d = drop_base;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_base != 16'hFFFF) begin
                drop_cnt_d = drop_base + 16'd1;
            end
        end
    end

    assign wordValid    = word_valid_q;
    assign wordData     = word_data_q;
    assign fifoCount    = cnt_q;
    assign byteCount    = state_q;
    assign timeoutPulse = pulse_q;
    assign overflow     = ovf_q;
    assign dropCount    = drop_cnt_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: stimulus pushes expected words into a queue,
// a forked monitor pops and compares on every accepted handshake.
module tb_uart_word_assembler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned T     = 8680;

    logic        clk;
    logic        reset;
    logic        byteValid;
    logic [7:0]  byteData;
    logic        wordValid;
    logic [31:0] wordData;
    logic        wordReady;
    logic [2:0]  fifoCount;
    logic [1:0]  byteCount;
    logic        timeoutPulse;
    logic        overflow;
    logic [15:0] dropCount;
    logic        clearStatus;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];

    uart_word_assembler #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .byteValid    (byteValid),
        .byteData     (byteData),
        .wordValid    (wordValid),
        .wordData     (wordData),
        .wordReady    (wordReady),
        .fifoCount    (fifoCount),
        .byteCount    (byteCount),
        .timeoutPulse (timeoutPulse),
        .overflow     (overflow),
        .dropCount    (dropCount),
        .clearStatus  (clearStatus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byteValid = 1'b1;
        byteData  = b;
        @(posedge clk);
        #1;
        byteValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic drain(input string name);
        wordReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (fifoCount == 3'd0) break;
        end
        wordReady = 1'b0;
        check({name, "_count"}, 32'(fifoCount), 32'd0);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_wordValid"}, 32'(wordValid), 32'd0);
        check({name, "_wordData"}, wordData, 32'd0);
        check({name, "_fifoCount"}, 32'(fifoCount), 32'd0);
        check({name, "_byteCount"}, 32'(byteCount), 32'd0);
        check({name, "_timeoutPulse"}, 32'(timeoutPulse), 32'd0);
        check({name, "_overflow"}, 32'(overflow), 32'd0);
        check({name, "_dropCount"}, 32'(dropCount), 32'd0);
    endtask

    initial begin
        int          pulses;
        int          first_at;
        logic [31:0] w;

        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        byteValid   = 1'b0;
        byteData    = '0;
        wordReady   = 1'b0;
        clearStatus = 1'b0;

        // Monitor: compares the head word against the scoreboard on each accepted handshake
        fork
            forever begin
                logic [31:0] e;
                @(negedge clk);
                if (!reset && wordValid && wordReady) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected actual=%0h required=none", wordData);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_word", wordData, e);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Single word, latency and byte ordering
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("t1_bytecount3", 32'(byteCount), 32'd3);
        check("t1_valid_early", 32'(wordValid), 32'd0);
        exp_q.push_back(32'h44332211);
        send_byte(8'h44);
        check("t1_valid", 32'(wordValid), 32'd1);
        check("t1_data", wordData, 32'h44332211);
        check("t1_bytecount0", 32'(byteCount), 32'd0);
        drain("t1_drain");

        // Overflow: five words into a four-deep FIFO
        for (int i = 0; i < 5; i++) begin
            w = 32'hA0B0C0D0 + 32'(i);
            if (i < 4) exp_q.push_back(w);
            send_word(w);
        end
        check("t2_count", 32'(fifoCount), 32'd4);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_drops", 32'(dropCount), 32'd1);
        drain("t2_drain");
        check("t2_overflow_sticky", 32'(overflow), 32'd1);
        clearStatus = 1'b1;
        @(posedge clk);
        #1;
        clearStatus = 1'b0;
        check("t2_clear_ovf", 32'(overflow), 32'd0);
        check("t2_clear_drops", 32'(dropCount), 32'd0);

        // Timeout discards a partial word
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("t3_bytecount2", 32'(byteCount), 32'd2);
        pulses   = 0;
        first_at = 0;
        for (int i = 1; i <= int'(T) + 2; i++) begin
            @(posedge clk);
            #1;
            if (timeoutPulse) begin
                pulses++;
                if (first_at == 0) first_at = i;
            end
        end
        check("t3_pulses", 32'(pulses), 32'd1);
        check("t3_pulse_cycle", 32'(first_at), 32'(T));
        check("t3_bytecount0", 32'(byteCount), 32'd0);
        exp_q.push_back(32'h04030201);
        send_word(32'h04030201);
        check("t3_valid", 32'(wordValid), 32'd1);
        drain("t3_drain");

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 4; i++) begin
            w = 32'h10203040 + 32'(i);
            exp_q.push_back(w);
            send_word(w);
        end
        check("t4_full", 32'(fifoCount), 32'd4);
        exp_q.push_back(32'hDEADBEEF);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        byteValid = 1'b1;
        byteData  = 8'hDE;
        wordReady = 1'b1;
        @(posedge clk);
        #1;
        byteValid = 1'b0;
        wordReady = 1'b0;
        check("t4_count", 32'(fifoCount), 32'd4);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_drops", 32'(dropCount), 32'd0);
        drain("t4_drain");

        // Reset mid-word with queued words
        for (int i = 0; i < 3; i++) begin
            w = 32'h55000000 + 32'(i);
            exp_q.push_back(w);
            send_word(w);
        end
        send_byte(8'h77);
        send_byte(8'h88);
        check("t5_pre_count", 32'(fifoCount), 32'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check_all_zero("t5_reset");
        reset = 1'b0;
        exp_q.push_back(32'hCAFEF00D);
        send_word(32'hCAFEF00D);
        check("t5_count", 32'(fifoCount), 32'd1);
        drain("t5_drain");

        // Byte on the exact expiry cycle wins over the timeout
        send_byte(8'hAA);
        pulses = 0;
        for (int i = 0; i < int'(T) - 1; i++) begin
            @(posedge clk);
            #1;
            if (timeoutPulse) pulses++;
        end
        send_byte(8'hBB);
        if (timeoutPulse) pulses++;
        check("t6_bytecount2", 32'(byteCount), 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (timeoutPulse) pulses++;
        end
        check("t6_no_pulse", 32'(pulses), 32'd0);
        exp_q.push_back(32'hDDCCBBAA);
        send_byte(8'hCC);
        send_byte(8'hDD);
        check("t6_valid", 32'(wordValid), 32'd1);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
